// File: rtl/pwm_fader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pwm_fader : bus-programmed duty ramp that feeds one write per step into the
//             downstream pwm driver. Optional done flag: PWM_FADER_DONE_IRQ_EN
// Revision  : 1.0
// ---------------------------------------------------------------------------
module pwm_fader #(
  parameter int WIDTH      = 4,
  parameter int RATE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wstrb,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pwm_sel,
  output logic        pwm_wstrb,
  output logic [31:0] pwm_wdata
`ifdef PWM_FADER_DONE_IRQ_EN
  ,
  output logic        done_irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic [WIDTH-1:0]      r_target, r_current, w_current_next;
  logic [RATE_WIDTH-1:0] r_rate, r_counter, w_counter_next;
  logic                  r_en, r_sync;
  logic                  w_wr, w_ctrl_wr, w_jump, w_halt, w_busy, w_step, w_done;
  logic                  w_unused;

  assign w_wr      = sel & wstrb;
  assign w_ctrl_wr = w_wr && (addr == 2'd2);
  assign w_jump    = w_ctrl_wr && wdata[1];
  // A CTRL write that clears EN (or jumps) cancels any step due on that edge.
  assign w_halt    = w_jump || (w_ctrl_wr && !wdata[0]);
  assign w_busy    = r_en && (r_current != r_target);
  assign w_unused  = &{1'b0, wdata};

  assign w_current_next = (r_current < r_target) ? r_current + WIDTH'(1)
                                                 : r_current - WIDTH'(1);

  always_comb begin
    w_state_next   = r_state;
    w_counter_next = r_counter;
    w_step         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_counter_next = '0;
        if (w_busy) w_state_next = ST_RAMP;
      end
      ST_RAMP: begin
        if (!w_busy) begin
          w_state_next   = ST_IDLE;
          w_counter_next = '0;
        end else if (r_counter == r_rate) begin
          w_state_next   = ST_UPDATE;
          w_counter_next = '0;
          w_step         = 1'b1;
        end else begin
          w_counter_next = r_counter + RATE_WIDTH'(1);
        end
      end
      ST_UPDATE: begin
        w_counter_next = '0;
        w_state_next   = w_busy ? ST_RAMP : ST_IDLE;
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_counter_next = '0;
      end
    endcase
    if (w_halt) begin
      w_state_next   = ST_IDLE;
      w_counter_next = '0;
      w_step         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
      r_target  <= '0;
      r_rate    <= '0;
      r_en      <= 1'b0;
      r_current <= '0;
      r_sync    <= 1'b1;
      pwm_sel   <= 1'b0;
      pwm_wstrb <= 1'b0;
      pwm_wdata <= '0;
    end else begin
      r_state   <= w_state_next;
      r_counter <= w_counter_next;
      r_sync    <= 1'b0;
      pwm_sel   <= 1'b0;
      pwm_wstrb <= 1'b0;
      if (w_wr && addr == 2'd0) r_target <= wdata[WIDTH-1:0];
      if (w_wr && addr == 2'd1) r_rate   <= wdata[RATE_WIDTH-1:0];
      if (w_ctrl_wr)            r_en     <= wdata[0];
      if (w_jump) begin
        r_current <= r_target;
        pwm_sel   <= 1'b1;
        pwm_wstrb <= 1'b1;
        pwm_wdata <= 32'(r_target);
      end else if (w_step) begin
        r_current <= w_current_next;
        pwm_sel   <= 1'b1;
        pwm_wstrb <= 1'b1;
        pwm_wdata <= 32'(w_current_next);
      end else if (r_sync) begin
        // First cycle out of reset: bring the driver in line with current.
        pwm_sel   <= 1'b1;
        pwm_wstrb <= 1'b1;
        pwm_wdata <= 32'(r_current);
      end
    end
  end

`ifdef PWM_FADER_DONE_IRQ_EN
  logic r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else if (w_jump || (w_step && w_current_next == r_target)) begin
      r_done <= 1'b1;
    end else if (w_ctrl_wr && wdata[2]) begin
      r_done <= 1'b0;
    end
  end

  assign done_irq = r_done;
  assign w_done   = r_done;
`else
  assign w_done   = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = 32'(r_target);
      2'd1:    rdata = 32'(r_rate);
      2'd2:    rdata = {31'd0, r_en};
      default: rdata = {14'd0, w_done, w_busy, 16'(r_current)};
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fader.sv
`default_nettype none
// tb_pwm_fader: register vectors, hand-written fade sequences and random
// ramps compared against a step/timing model of pwm_fader.
module tb_pwm_fader;
  logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, wstrb = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata, pwm_wdata;
  logic        pwm_sel, pwm_wstrb;
`ifdef PWM_FADER_DONE_IRQ_EN
  logic        done_irq;
  localparam logic [31:0] SMASK = 32'hFFFD_FFFF;
`else
  localparam logic [31:0] SMASK = 32'hFFFF_FFFF;
`endif

  pwm_fader #(.WIDTH(4), .RATE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .rdata(rdata), .pwm_sel(pwm_sel), .pwm_wstrb(pwm_wstrb), .pwm_wdata(pwm_wdata)
`ifdef PWM_FADER_DONE_IRQ_EN
    , .done_irq(done_irq)
`endif
  );

  typedef struct { int c; logic [31:0] d; logic s; } pulse_t;
  typedef struct { logic [1:0] wa; logic [31:0] wd; logic [1:0] ra; logic [31:0] exp; } vec_t;

  pulse_t pq[$];
  int     n_cmp = 0, n_bad = 0, cyc = 0, wcyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (pwm_sel || pwm_wstrb) pq.push_back('{cyc, pwm_wdata, pwm_sel & pwm_wstrb});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
    tick(1);
    wcyc = cyc;
    sel = 1'b0; wstrb = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1 v = rdata;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k = 0;
    while (pq.size() < n && k < budget) begin tick(1); k++; end
    check({name, "_count"}, pq.size(), n);
  endtask

  function automatic logic [31:0] pd(input int i);
    return (i < pq.size()) ? pq[i].d : 32'hDEAD_BEEF;
  endfunction

  function automatic int pc(input int i);
    return (i < pq.size()) ? pq[i].c : -1;
  endfunction

  initial begin
    vec_t        vt[8];
    logic [31:0] v;
    int          w0, mcur, t, r, n;

    vt[0] = '{2'd0, 32'h0000_00F5, 2'd0, 32'h0000_0005};
    vt[1] = '{2'd1, 32'hABCD_1234, 2'd1, 32'h0000_1234};
    vt[2] = '{2'd2, 32'hFFFF_FFF8, 2'd2, 32'h0000_0000};
    vt[3] = '{2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    vt[4] = '{2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vt[5] = '{2'd1, 32'h0000_0002, 2'd1, 32'h0000_0002};
    vt[6] = '{2'd2, 32'hFFFF_FFF1, 2'd2, 32'h0000_0001};
    vt[7] = '{2'd3, 32'h0000_0000, 2'd3, 32'h0000_0000};

    // Reset release: exactly one sync pulse carrying 0.
    tick(3);
    rst = 1'b0;
    tick(8);
    check("sync_count", pq.size(), 1);
    check("sync_wdata", pd(0), 32'd0);
    rd(2'd3, v);
    check("reset_status", v, 32'd0);
    pq.delete();

    for (int i = 0; i < 8; i++) begin
      wr(vt[i].wa, vt[i].wd);
      rd(vt[i].ra, v);
      check($sformatf("reg_vec%0d", i), v & ((vt[i].ra == 2'd3) ? SMASK : 32'hFFFF_FFFF), vt[i].exp);
    end
    check("reg_no_pulse", pq.size(), 0);

    // Up-ramp 0 -> 5 at RATE=2 (EN already set).
    wr(2'd0, 32'd5);
    w0 = wcyc;
    wait_pulses(5, 40, "up");
    tick(10);
    check("up_total", pq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("up_wdata%0d", k), pd(k), 32'(k + 1));
      check($sformatf("up_time%0d", k), 32'(pc(k) - w0), 32'(4 * (k + 1)));
    end
    check("up_strobe", {31'd0, pq[0].s & pq[4].s}, 32'd1);
    rd(2'd3, v);
    check("up_status", v & SMASK, 32'd5);

    // Reversal: retarget to 1 once current reaches 3.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd0);
    wr(2'd2, 32'd2);
    wr(2'd2, 32'd1);
    pq.delete();
    wr(2'd0, 32'd5);
    wait_pulses(3, 30, "rev_a");
    wr(2'd0, 32'd1);
    wait_pulses(5, 30, "rev_b");
    tick(10);
    check("rev_total", pq.size(), 5);
    check("rev_p3", pd(3), 32'd2);
    check("rev_p4", pd(4), 32'd1);
    rd(2'd3, v);
    check("rev_status", v & SMASK, 32'd1);

    // JUMP with EN=0.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd15);
    wr(2'd1, 32'd100);
    pq.delete();
    wr(2'd2, 32'd2);
    w0 = wcyc;
    tick(6);
    check("jump_count", pq.size(), 1);
    check("jump_wdata", pd(0), 32'd15);
    check("jump_time", 32'(pc(0) - w0), 32'd0);
    rd(2'd3, v);
    check("jump_status", v & SMASK, 32'd15);

    // EN cleared after the third step of a 0 -> 10 ramp at RATE=0.
    wr(2'd0, 32'd0);
    wr(2'd2, 32'd2);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd1);
    pq.delete();
    wr(2'd0, 32'd10);
    wait_pulses(3, 20, "encl");
    wr(2'd2, 32'd0);
    tick(20);
    check("encl_total", pq.size(), 3);
    rd(2'd3, v);
    check("encl_status", v & SMASK, 32'd3);

    // Random ramps against a step/timing model.
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd1);
    mcur = 3;
    for (int trial = 0; trial < 8; trial++) begin
      t = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 4));
      n = (t > mcur) ? t - mcur : mcur - t;
      wr(2'd1, 32'(r));
      pq.delete();
      wr(2'd0, 32'(t));
      w0 = wcyc;
      wait_pulses(n, n * (r + 2) + 10, $sformatf("rnd%0d", trial));
      tick(4);
      check($sformatf("rnd%0d_total", trial), pq.size(), n);
      for (int k = 0; k < n; k++) begin
        check($sformatf("rnd%0d_wdata%0d", trial, k), pd(k),
              32'((t > mcur) ? mcur + k + 1 : mcur - k - 1));
        check($sformatf("rnd%0d_time%0d", trial, k), 32'(pc(k) - w0), 32'((k + 1) * (r + 2)));
      end
      mcur = t;
      rd(2'd3, v);
      check($sformatf("rnd%0d_status", trial), v & SMASK, 32'(t));
    end

    // Reset in the middle of a ramp, then another sync pulse.
    wr(2'd1, 32'd3);
    wr(2'd0, (mcur > 7) ? 32'd0 : 32'd15);
    tick(12);
    rst = 1'b1;
    tick(1);
    check("mid_rst_outs", {pwm_wdata[30:0], pwm_sel}, 32'd0);
    check("mid_rst_strb", {31'd0, pwm_wstrb}, 32'd0);
    rd(2'd3, v);
    check("mid_rst_status", v, 32'd0);
    rst = 1'b0;
    pq.delete();
    tick(6);
    check("mid_rst_sync", pq.size(), 1);
    check("mid_rst_sync_d", pd(0), 32'd0);

`ifdef PWM_FADER_DONE_IRQ_EN
    check("done_reset", {31'd0, done_irq}, 32'd0);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd1);
    pq.delete();
    wr(2'd0, 32'd2);
    wait_pulses(1, 20, "done_a");
    check("done_low", {31'd0, done_irq}, 32'd0);
    wait_pulses(2, 20, "done_b");
    check("done_high", {31'd0, done_irq}, 32'd1);
    rd(2'd3, v);
    check("done_status", v, 32'h0002_0002);
    wr(2'd2, 32'd5);
    check("done_clr", {31'd0, done_irq}, 32'd0);
    rd(2'd2, v);
    check("done_en_kept", v, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_fader.md
# pwm_fader

Bus-side duty-cycle ramp controller that sits directly upstream of the `pwm` LED driver in the RISC-V SoC. The CPU writes a target duty, a step rate and control bits over the peripheral bus. The block then walks the current duty one LSB at a time toward the target, issuing one single-cycle write (`sel`/`wstrb`/`wdata`) to the `pwm` driver per step. Software gets smooth fades without polling.

## Interface
- `WIDTH`, 4: duty width; must match the downstream `pwm` `WIDTH`.
- `RATE_WIDTH`, 16: width of the step-period register.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sel`  in  1: bus select for this peripheral.
- `wstrb`  in  1: bus write strobe; a write occurs on an edge where `sel & wstrb`.
- `addr`  in  2: register index.
- `wdata`  in  32: bus write data.
- `rdata`  out  32: combinational read data for `addr`.
- `pwm_sel`  out  1: select to the `pwm` driver.
- `pwm_wstrb`  out  1: write strobe to the `pwm` driver.
- `pwm_wdata`  out  32: duty to the `pwm` driver; `current` zero-extended.

## Operation
- Registers:
  - addr 0 TARGET[WIDTH-1:0].
  - addr 1 RATE[RATE_WIDTH-1:0].
  - addr 2 CTRL: bit0 EN (stored), bit1 JUMP (self-clearing action), bit2 IRQCLR (action, only with macro).
  - addr 3 STATUS, read-only: [WIDTH-1:0] = current, bit 16 = busy, bit 17 = done (0 without macro).
- Upper `wdata` bits are ignored. Writes to addr 3 are ignored. Reads of addr 0–2 return the stored fields zero-extended.
- `busy` = EN && current != TARGET.
- States:
  - IDLE: counter held 0.
  - RAMP: counter increments each cycle.
  - UPDATE: a one-cycle pulse.
- Transitions:
  - IDLE→RAMP when `busy` becomes 1.
  - RAMP→UPDATE on the edge where counter == RATE.
  - UPDATE→RAMP if still busy, else →IDLE.
- UPDATE edge actions:
  - counter:=0.
  - current moves ±1 toward TARGET. Direction is evaluated at this edge, so a mid-ramp TARGET change reverses or extends the ramp without resetting the counter.
  - `pwm_sel` = `pwm_wstrb` = 1 for exactly that cycle, with `pwm_wdata` = the new current.
- No wrap-around: current never steps past TARGET or outside 0..2^WIDTH-1.
- JUMP (a CTRL write with bit1 set):
  - current:=TARGET immediately and one pulse is emitted, regardless of EN.
  - counter:=0 and the state goes to IDLE.
  - The EN bit from the same write is still stored.
- EN cleared mid-ramp: current freezes, counter:=0, state goes to IDLE, no further pulses.
- Simultaneous TARGET write and UPDATE edge: the step uses the old TARGET; the new TARGET applies from the next cycle.
- RATE=0 gives one step every 2 cycles (RAMP 1 cycle + UPDATE 1 cycle).
- Reset values:
  - TARGET=0, RATE=0, EN=0, current=0, counter=0, state IDLE.
  - `pwm_sel` = `pwm_wstrb` = 0, `pwm_wdata` = 0, `done_irq` = 0.
- Post-reset sync: in the first cycle after `rst` deasserts, one pulse with `pwm_wdata` = 0 is emitted so the driver matches current.

## Timing
- Bus writes take effect at the edge where `sel & wstrb`. `rdata` reflects them one cycle later.
- First step pulse follows a TARGET write (EN=1, was idle) by RATE+2 cycles: one cycle to enter RAMP, then RATE+1 cycles to reach UPDATE.
- Steady ramp: one pulse every RATE+2 cycles.
- All `pwm_*` outputs are registered; no combinational path from bus to `pwm_*`.
- JUMP pulse is asserted in the cycle after the CTRL write edge.
- Reset asserted mid-ramp: outputs return to reset values on that edge; any in-flight pulse is dropped.

## Configuration
- `PWM_FADER_DONE_IRQ_EN` defined:
  - Adds output port `done_irq` (1 bit).
  - `done_irq` is a sticky flag, set on the UPDATE edge where current reaches TARGET, and on JUMP.
  - Cleared by a CTRL write with bit2 set. Set wins over clear on the same edge.
  - Mirrored in STATUS bit 17.
- Undefined: no `done_irq` port, CTRL bit2 is ignored, STATUS bit 17 reads 0.

## Test plan
- Reset release: `rst` low after 3 cycles -> exactly one pulse with `pwm_wdata`=0, then no activity; STATUS=0.
- Up-ramp:
  - Stimulus: RATE=2, CTRL=1, TARGET=5.
  - Pulses with wdata 1,2,3,4,5, each 4 cycles apart; first pulse 4 cycles after the TARGET write.
  - Then IDLE with busy=0.
- Reversal: during the up-ramp at current=3, write TARGET=1 -> next pulses are 2,1; no pulse exceeds 3.
- Disable/JUMP:
  - Stimulus: with EN=0, TARGET=15, RATE=100, write CTRL=2.
  - Single pulse wdata=15 the next cycle; STATUS current=15, busy=0.
- EN cleared mid-ramp: ramp 0→10 at RATE=0, clear EN after the third pulse -> no further pulses; current stays 3.
- (Macro on) Done flag:
  - Ramp 0→2 -> `done_irq` rises on the edge of the pulse with wdata=2.
  - A CTRL write of 0x5 clears it; EN stays 1.
